// File: rtl/vc_arbiter.sv
// Round-robin drain of four upstream FIFOs into four downstream FIFOs selected by the
// destination field of each word; two-stage pop -> push pipeline with shared state control.
module vc_arbiter #(
    parameter int DATA_W   = 12,
    parameter int N_IN     = 4,
    parameter int DEST_MSB = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        state,
    input  logic [N_IN-1:0]   in_empty,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    output logic [N_IN-1:0]   in_pop,
    input  logic [3:0]        out_afull,
    output logic [3:0]        out_push,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        grant,
    output logic [15:0]       xfer_count
);

    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    logic [1:0]        rr_q, rr_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        grant_q, grant_d;
    logic              pipe_v_q, pipe_v_d;
    logic [3:0]        push_q, push_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       xfer_q, xfer_d;

    logic              clear;
    logic              pop_en;
    logic [N_IN-1:0]   elig;
    logic [1:0]        pick;
    logic [1:0]        idx;
    logic              found;
    logic [DATA_W-1:0] sel_word;
    logic [1:0]        dest;

    assign clear  = !reset || (state == ST_RESET);
    // Any almost_full bit stalls every input: the shared write port cannot be steered away.
    assign pop_en = reset && (state == ST_ACTIVE) && (out_afull == 4'b0000);
    assign elig   = pop_en ? ~in_empty : '0;

    // Scanning from the far end lets the last hit be the first eligible one after rr.
    always_comb begin
        pick  = rr_q;
        idx   = rr_q;
        found = 1'b0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            idx = rr_q + 2'(k);
            if (elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign in_pop = found ? ({{(N_IN-1){1'b0}}, 1'b1} << pick) : '0;

    always_comb begin
        case (sel_q)
            2'd0:    sel_word = in_data0;
            2'd1:    sel_word = in_data1;
            2'd2:    sel_word = in_data2;
            default: sel_word = in_data3;
        endcase
    end

    assign dest = sel_word[DEST_MSB -: 2];

    always_comb begin
        rr_d     = rr_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        pipe_v_d = found;
        push_d   = 4'b0000;
        data_d   = data_q;
        xfer_d   = xfer_q;
        if (found) begin
            rr_d    = pick + 2'd1;
            sel_d   = pick;
            grant_d = pick;
        end
        // The upstream FIFO presents the popped word one cycle after the pop.
        if (pipe_v_q) begin
            data_d = sel_word;
            push_d = 4'b0001 << dest;
            xfer_d = xfer_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            rr_q     <= 2'd0;
            sel_q    <= 2'd0;
            grant_q  <= 2'd0;
            pipe_v_q <= 1'b0;
            push_q   <= 4'b0000;
            data_q   <= '0;
            xfer_q   <= 16'd0;
        end else begin
            rr_q     <= rr_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            pipe_v_q <= pipe_v_d;
            push_q   <= push_d;
            data_q   <= data_d;
            xfer_q   <= xfer_d;
        end
    end

    assign out_push   = push_q;
    assign out_data   = data_q;
    assign grant      = grant_q;
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Bench for vc_arbiter: directed scenarios with literal expectations plus a long random run
// compared every cycle against a behavioural model of the arbiter.
module tb_vc_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  state;
    logic [3:0]  in_empty;
    logic [11:0] d [4];
    logic [3:0]  in_pop;
    logic [3:0]  out_afull;
    logic [3:0]  out_push;
    logic [11:0] out_data;
    logic [1:0]  grant;
    logic [15:0] xfer_count;

    int total  = 0;
    int passed = 0;
    bit chk_en = 0;

    vc_arbiter #(.DATA_W(12), .N_IN(4), .DEST_MSB(11)) dut (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .in_empty   (in_empty),
        .in_data0   (d[0]),
        .in_data1   (d[1]),
        .in_data2   (d[2]),
        .in_data3   (d[3]),
        .in_pop     (in_pop),
        .out_afull  (out_afull),
        .out_push   (out_push),
        .out_data   (out_data),
        .grant      (grant),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: which input may be popped now, and what the outputs must show.
    int          m_rr = 0;
    int          m_inflight = -1;
    logic [3:0]  e_push;
    logic [11:0] e_data;
    logic [1:0]  e_grant;
    logic [15:0] e_xfer;

    function automatic int model_pick();
        if (!reset || state != 4'b1000 || out_afull != 4'b0000) return -1;
        for (int k = 0; k < 4; k++) begin
            if (!in_empty[(m_rr + k) % 4]) return (m_rr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_pop();
        int p;
        p = model_pick();
        return (p < 0) ? 4'b0000 : 4'(1 << p);
    endfunction

    always @(posedge clk) begin
        if (!reset || state == 4'b0001) begin
            e_push     <= 4'b0000;
            e_data     <= 12'h000;
            e_grant    <= 2'd0;
            e_xfer     <= 16'd0;
            m_rr       <= 0;
            m_inflight <= -1;
        end else begin
            if (m_inflight >= 0) begin
                e_data <= d[m_inflight];
                e_push <= 4'b0001 << d[m_inflight][11:10];
                e_xfer <= e_xfer + 16'd1;
            end else begin
                e_push <= 4'b0000;
            end
            if (model_pick() >= 0) begin
                e_grant <= 2'(model_pick());
                m_rr    <= (model_pick() + 1) % 4;
            end
            m_inflight <= model_pick();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_in_pop",     32'(in_pop),     32'(model_pop()));
            check("cmp_out_push",   32'(out_push),   32'(e_push));
            check("cmp_out_data",   32'(out_data),   32'(e_data));
            check("cmp_grant",      32'(grant),      32'(e_grant));
            check("cmp_xfer_count", 32'(xfer_count), 32'(e_xfer));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rr();
        cyc();
        state    = 4'b0001;
        in_empty = 4'b1111;
        cyc();
        state    = 4'b1000;
    endtask

    int pushes;

    initial begin
        reset     = 1'b0;
        state     = 4'b1000;
        in_empty  = 4'b0000;
        out_afull = 4'b0000;
        for (int i = 0; i < 4; i++) d[i] = 12'h000;

        // Reset held low while ACTIVE with everything non-empty
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk_en = 1'b1;
            @(negedge clk);
            check("t1_in_pop", 32'(in_pop), 32'h0);
        end
        check("t1_out_push", 32'(out_push),   32'h0);
        check("t1_out_data", 32'(out_data),   32'h0);
        check("t1_xfer",     32'(xfer_count), 32'h0);

        // Single word from input 0, dest 3
        cyc();
        reset    = 1'b1;
        state    = 4'b0001;
        in_empty = 4'b1111;
        cyc();
        state    = 4'b1000;
        in_empty = 4'b1110;
        d[0]     = 12'hC05;
        @(negedge clk);
        check("t2_pop_n", 32'(in_pop), 32'h1);
        cyc();
        in_empty = 4'b1111;
        @(negedge clk);
        check("t2_push_n1", 32'(out_push), 32'h0);
        cyc();
        @(negedge clk);
        check("t2_push_n2", 32'(out_push),   32'h8);
        check("t2_data_n2", 32'(out_data),   32'hC05);
        check("t2_xfer",    32'(xfer_count), 32'h1);
        check("t2_grant",   32'(grant),      32'h0);

        // Round-robin over four always-ready inputs
        clear_rr();
        in_empty = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            for (int i = 0; i < 4; i++) d[i] = 12'($urandom);
            @(negedge clk);
            check("t3_pop_seq", 32'(in_pop), 32'(1 << (k % 4)));
            if (k > 0) check("t3_grant_seq", 32'(grant), 32'((k - 1) % 4));
        end
        cyc();
        in_empty = 4'b1111;
        @(negedge clk);
        check("t3_grant_last", 32'(grant), 32'h3);
        cyc();
        cyc();
        @(negedge clk);
        check("t3_xfer", 32'(xfer_count), 32'h8);

        // Backpressure while streaming
        in_empty = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            cyc();
            for (int i = 0; i < 4; i++) d[i] = 12'($urandom);
        end
        cyc();
        out_afull = 4'b0100;
        @(negedge clk);
        check("t4_pop_stall", 32'(in_pop), 32'h0);
        pushes = (out_push != 4'b0000) ? 1 : 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            @(negedge clk);
            if (out_push != 4'b0000) pushes++;
        end
        check("t4_push_after_af", 32'(pushes), 32'd2);
        cyc();
        out_afull = 4'b0000;
        @(negedge clk);
        check("t4_resume", 32'(in_pop != 4'b0000), 32'h1);

        // Leaving ACTIVE with a word in flight
        clear_rr();
        in_empty = 4'b1110;
        d[0]     = 12'h4A7;
        @(negedge clk);
        check("t5_pop_n", 32'(in_pop), 32'h1);
        cyc();
        state    = 4'b0100;
        in_empty = 4'b0000;
        @(negedge clk);
        check("t5_pop_n1", 32'(in_pop), 32'h0);
        cyc();
        @(negedge clk);
        check("t5_push_n2", 32'(out_push), 32'h2);
        check("t5_data_n2", 32'(out_data), 32'h4A7);
        check("t5_pop_n2",  32'(in_pop),   32'h0);

        // Reset pulse while a word is in flight
        clear_rr();
        in_empty = 4'b1101;
        @(negedge clk);
        check("t6_pop_n", 32'(in_pop), 32'h2);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("t6_pop_rst", 32'(in_pop), 32'h0);
        cyc();
        reset    = 1'b1;
        in_empty = 4'b0000;
        @(negedge clk);
        check("t6_push_n2", 32'(out_push),   32'h0);
        check("t6_xfer",    32'(xfer_count), 32'h0);
        check("t6_rr_zero", 32'(in_pop),     32'h1);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            cyc();
            reset = ($urandom_range(0, 99) != 0);
            case ($urandom_range(0, 19))
                0:       state = 4'b0001;
                1:       state = 4'b0010;
                2, 3:    state = 4'b0100;
                default: state = 4'b1000;
            endcase
            in_empty  = 4'($urandom) & 4'($urandom);
            out_afull = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            for (int i = 0; i < 4; i++) d[i] = 12'($urandom);
        end
        cyc();
        cyc();
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
